stopwatch_time_counter: RTL and testbench
=========================================

# stopwatch_time_counter

Consumes the 100 Hz clock-divider output and turns it into stopwatch time: a BCD minutes:seconds.centiseconds count with start/stop, clear and optional lap-hold control. Sits between the 50 MHz-to-100 Hz divider and the seven-segment display driver, and runs entirely in the CLK_50_MHz domain. The divider output is treated as a data input, never as a clock.

## Interface
- MAX_MINUTES, default 59: highest minutes value; the count wraps after MAX_MINUTES:59.99. The legal range is 1..99.
- CLK_50_MHz, input, 1: the only clock.
- reset_n, input, 1: asynchronous, active-low reset.
- CLK_100Hz, input, 1: divider output, asynchronous to this block; each rising edge is one centisecond.
- btn_start_stop, input, 1: debounced level; each rising edge toggles run/stop.
- btn_clear, input, 1: debounced level; each rising edge zeroes the count and stops.
- btn_lap, input, 1: debounced level; each rising edge toggles lap hold (only with LAP_HOLD_EN).
- cs_tens, cs_ones, sec_tens, sec_ones, min_tens, min_ones, output, 4 each: displayed BCD digits.
- running, output, 1: the count is advancing.
- lap_active, output, 1: the display is frozen while counting continues.
- wrap, output, 1: one-cycle pulse when the count wraps to 00:00.00.

## Operation
- Every asynchronous input passes through a 2-FF synchronizer, then a rising-edge detector (a registered previous value): tick, ev_ss, ev_clr, ev_lap.
- FSM states:
  - STOPPED (the reset state): ev_ss goes to RUNNING.
  - RUNNING: ev_ss goes to STOPPED; ev_lap goes to LAP.
  - LAP: ev_lap goes to RUNNING; ev_ss goes to STOPPED and releases the display.
  - ev_clr from any state goes to STOPPED.
- The internal count advances on tick only in RUNNING or LAP.
- Digit chain: cs_ones 0-9, then cs_tens 0-9, then sec_ones 0-9, then sec_tens 0-5, then min_ones 0-9, then min_tens. Each digit carries when it is at its maximum and the lower carry is active.
- At MAX_MINUTES:59.99, a tick loads all zeros and pulses wrap. The count keeps running.
- Display registers follow the internal count in STOPPED and RUNNING. They hold their value in LAP.
- Digits never leave the BCD range. Each tick advances the count by exactly one. Values are never skipped or repeated.
- Priority in a single cycle is ev_clr, then ev_ss, then ev_lap. If tick coincides with ev_clr, the count becomes zero and the tick is dropped. If tick coincides with ev_ss leaving RUNNING, the tick is counted.
- If ev_ss and ev_lap arrive in the same cycle, ev_ss applies and ev_lap is dropped.
- Reset values: all digits 0, running 0, lap_active 0, wrap 0, FSM in STOPPED, synchronizer and edge registers 0. Reset may assert at any time, mid-count included, and forces these values at once.

## Timing
- Synchronizer plus edge detector: an input rising edge first sampled at clock edge k raises the event for the cycle between edges k+2 and k+3.
- The count and display update at edge k+3. With respect to the first sampling edge, the latency is 3 cycles.
- running, lap_active and wrap are registered and change at the same edge as the count.
- wrap is high for exactly one cycle per wrap.
- Events closer than 3 cycles apart on the same input are not guaranteed to be resolved. Inputs are debounced upstream.

## Configuration
- LAP_HOLD_EN defined: the LAP state, the lap edge detector and display holding are built.
- LAP_HOLD_EN undefined:
  - btn_lap is present but ignored.
  - lap_active is tied to 0.
  - The FSM has only STOPPED and RUNNING.
  - The display always equals the internal count.

## Structure
- Shared package stopwatch_pkg holds:
  - the FSM state enum (STOPPED, RUNNING, LAP);
  - the BCD digit width (4);
  - the digit limits CS_MAX=9 and SEC_TENS_MAX=5.
- One sub-module, bcd_digit_counter, is instantiated six times. Its ports are: clock, reset, clear, enable, max value, digit, carry out.

## Test plan
- Reset release, then ev_ss, then 150 CLK_100Hz edges: display shows 00:01.50, running=1.
- Preload 00:59.99 in RUNNING, then one tick: display 01:00.00, no wrap pulse.
- Preload 59:59.99 in RUNNING, then one tick: display 00:00.00, wrap high for 1 cycle, running stays 1.
- btn_clear rising edge in the same cycle as tick at 00:12.34: display 00:00.00, running=0.
- LAP_HOLD_EN defined, lap at 00:05.00, then 300 ticks: display holds 00:05.00. A second lap shows 00:08.00.
- reset_n pulsed low at 00:42.17 while running: all outputs 0 immediately. The FSM is STOPPED after release, and ticks do not advance the count.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and digit limits for the stopwatch time counter.
package stopwatch_pkg;

  localparam int unsigned DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] digit_t;

  localparam digit_t CS_MAX       = 4'd9;
  localparam digit_t SEC_TENS_MAX = 4'd5;

  typedef enum logic [1:0] {
    STOPPED = 2'd0,
    RUNNING = 2'd1,
    LAP     = 2'd2
  } state_t;

endpackage

// File: rtl/stopwatch_time_counter_digit.sv
// bcd_digit_counter: one BCD digit, rolls to zero after max_value.
// carry_out is combinational so a whole chain advances in a single cycle.
module bcd_digit_counter
  import stopwatch_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               enable,
  input  logic [DIGIT_W-1:0] max_value,
  output logic [DIGIT_W-1:0] digit,
  output logic               carry_out
);

  assign carry_out = enable && (digit == max_value);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit <= '0;
    end else if (clear) begin
      digit <= '0;
    end else if (enable) begin
      digit <= carry_out ? '0 : digit + 4'd1;
    end
  end

endmodule

// File: rtl/stopwatch_time_counter.sv
// Stopwatch time counter: 100 Hz divider ticks -> BCD mm:ss.cc with start/stop/clear.
// Define LAP_HOLD_EN to build the LAP state, lap edge detector and display hold.
module stopwatch_time_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned MAX_MINUTES = 59
) (
  input  logic               CLK_50_MHz,
  input  logic               reset_n,
  input  logic               CLK_100Hz,
  input  logic               btn_start_stop,
  input  logic               btn_clear,
  input  logic               btn_lap,
  output logic [DIGIT_W-1:0] cs_tens,
  output logic [DIGIT_W-1:0] cs_ones,
  output logic [DIGIT_W-1:0] sec_tens,
  output logic [DIGIT_W-1:0] sec_ones,
  output logic [DIGIT_W-1:0] min_tens,
  output logic [DIGIT_W-1:0] min_ones,
  output logic               running,
  output logic               lap_active,
  output logic               wrap
);

  localparam digit_t MIN_TENS_LAST = digit_t'(MAX_MINUTES / 10);
  localparam digit_t MIN_ONES_LAST = digit_t'(MAX_MINUTES % 10);

`ifdef LAP_HOLD_EN
  localparam int unsigned NUM_IN = 4;
  logic [NUM_IN-1:0] async_in;
  assign async_in = {btn_lap, btn_clear, btn_start_stop, CLK_100Hz};
`else
  localparam int unsigned NUM_IN = 3;
  logic [NUM_IN-1:0] async_in;
  logic              unused_lap;
  assign async_in   = {btn_clear, btn_start_stop, CLK_100Hz};
  assign unused_lap = btn_lap;
`endif

  // Two-stage synchronizer, previous-value register, then a registered
  // rising-edge pulse so events land two cycles after the first sample.
  logic [NUM_IN-1:0] sync_a, sync_b, prev, ev;

  always_ff @(posedge CLK_50_MHz or negedge reset_n) begin
    if (!reset_n) begin
      sync_a <= '0;
      sync_b <= '0;
      prev   <= '0;
      ev     <= '0;
    end else begin
      sync_a <= async_in;
      sync_b <= sync_a;
      prev   <= sync_b;
      ev     <= sync_b & ~prev;
    end
  end

  logic tick, ev_ss, ev_clr;
  assign tick   = ev[0];
  assign ev_ss  = ev[1];
  assign ev_clr = ev[2];
`ifdef LAP_HOLD_EN
  logic ev_lap;
  assign ev_lap = ev[3];
`endif

  state_t state, state_next;

  always_ff @(posedge CLK_50_MHz or negedge reset_n) begin
    if (!reset_n) state <= STOPPED;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (ev_clr) begin
      state_next = STOPPED;
    end else if (ev_ss) begin
      state_next = (state == STOPPED) ? RUNNING : STOPPED;
    end
`ifdef LAP_HOLD_EN
    else if (ev_lap) begin
      if (state == RUNNING)  state_next = LAP;
      else if (state == LAP) state_next = RUNNING;
    end
`endif
  end

  digit_t cs_o, cs_t, s_o, s_t, m_o, m_t;
  logic   c_cs_o, c_cs_t, c_s_o, c_s_t, c_m_o, unused_carry;
  logic   count_en, at_max, roll, clear_all;

  // Count decisions use the pre-edge state: a tick with ev_ss leaving
  // RUNNING still counts, a tick with ev_clr is dropped.
  assign count_en  = tick && (state != STOPPED) && !ev_clr;
  assign at_max    = (m_t == MIN_TENS_LAST) && (m_o == MIN_ONES_LAST) &&
                     (s_t == SEC_TENS_MAX)  && (s_o == CS_MAX) &&
                     (cs_t == CS_MAX)       && (cs_o == CS_MAX);
  assign roll      = count_en && at_max;
  assign clear_all = ev_clr || roll;

  bcd_digit_counter u_cs_ones (
    .clk(CLK_50_MHz), .rst_n(reset_n), .clear(clear_all), .enable(count_en),
    .max_value(CS_MAX), .digit(cs_o), .carry_out(c_cs_o)
  );
  bcd_digit_counter u_cs_tens (
    .clk(CLK_50_MHz), .rst_n(reset_n), .clear(clear_all), .enable(c_cs_o),
    .max_value(CS_MAX), .digit(cs_t), .carry_out(c_cs_t)
  );
  bcd_digit_counter u_sec_ones (
    .clk(CLK_50_MHz), .rst_n(reset_n), .clear(clear_all), .enable(c_cs_t),
    .max_value(CS_MAX), .digit(s_o), .carry_out(c_s_o)
  );
  bcd_digit_counter u_sec_tens (
    .clk(CLK_50_MHz), .rst_n(reset_n), .clear(clear_all), .enable(c_s_o),
    .max_value(SEC_TENS_MAX), .digit(s_t), .carry_out(c_s_t)
  );
  bcd_digit_counter u_min_ones (
    .clk(CLK_50_MHz), .rst_n(reset_n), .clear(clear_all), .enable(c_s_t),
    .max_value(CS_MAX), .digit(m_o), .carry_out(c_m_o)
  );
  // The top of the count is caught by at_max, so min_tens never rolls itself.
  bcd_digit_counter u_min_tens (
    .clk(CLK_50_MHz), .rst_n(reset_n), .clear(clear_all), .enable(c_m_o),
    .max_value(CS_MAX), .digit(m_t), .carry_out(unused_carry)
  );

  always_ff @(posedge CLK_50_MHz or negedge reset_n) begin
    if (!reset_n) begin
      running <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      running <= (state_next != STOPPED);
      wrap    <= roll;
    end
  end

  logic [6*DIGIT_W-1:0] count_vec, disp_vec;
  assign count_vec = {m_t, m_o, s_t, s_o, cs_t, cs_o};

`ifdef LAP_HOLD_EN
  logic [6*DIGIT_W-1:0] held;

  always_ff @(posedge CLK_50_MHz or negedge reset_n) begin
    if (!reset_n) begin
      held       <= '0;
      lap_active <= 1'b0;
    end else begin
      if (state != LAP) held <= count_vec;
      lap_active <= (state_next == LAP);
    end
  end

  assign disp_vec = (state == LAP) ? held : count_vec;
`else
  assign lap_active = 1'b0;
  assign disp_vec   = count_vec;
`endif

  assign {min_tens, min_ones, sec_tens, sec_ones, cs_tens, cs_ones} = disp_vec;

endmodule

// File: tb/tb_stopwatch_time_counter.sv
// Scoreboard bench for stopwatch_time_counter, built with MAX_MINUTES=1 so the wrap is reachable.
module tb_stopwatch_time_counter;

  localparam int unsigned MAXM  = 1;
  localparam int unsigned TOTAL = (MAXM + 1) * 6000;
`ifdef LAP_HOLD_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  logic clk = 1'b0, reset_n = 1'b1;
  logic tick_in = 1'b0, ss = 1'b0, clr = 1'b0, lap = 1'b0;
  logic [3:0] cs_tens, cs_ones, sec_tens, sec_ones, min_tens, min_ones;
  logic running, lap_active, wrap;
  logic [23:0] obs;

  stopwatch_time_counter #(.MAX_MINUTES(MAXM)) dut (
    .CLK_50_MHz(clk), .reset_n(reset_n), .CLK_100Hz(tick_in),
    .btn_start_stop(ss), .btn_clear(clr), .btn_lap(lap),
    .cs_tens(cs_tens), .cs_ones(cs_ones), .sec_tens(sec_tens),
    .sec_ones(sec_ones), .min_tens(min_tens), .min_ones(min_ones),
    .running(running), .lap_active(lap_active), .wrap(wrap)
  );

  assign obs = {min_tens, min_ones, sec_tens, sec_ones, cs_tens, cs_ones};

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned wrap_cnt = 0;
  always @(negedge clk) if (wrap === 1'b1) wrap_cnt <= wrap_cnt + 1;

  typedef struct packed {
    logic [31:0] due;
    logic [23:0] disp;
    logic        run;
    logic        lapa;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_cmp = 0, n_bad = 0;
  int          mstate = 0;          // 0 stopped, 1 running, 2 lap
  int unsigned mcs = 0, mheld = 0;

  function automatic logic [23:0] to_bcd(input int unsigned t);
    int unsigned m = t / 6000;
    int unsigned s = (t / 100) % 60;
    int unsigned c = t % 100;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  task automatic step(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // m = {lap, clr, ss, tick}; updates the model, queues the expected result, pulses inputs.
  task automatic drive(input logic [3:0] m);
    exp_t        e;
    int unsigned pre;
    pre = mcs;
    if (m[2]) begin
      mstate = 0;
      mcs    = 0;
    end else begin
      if (m[0] && mstate != 0) mcs = (mcs + 1) % TOTAL;
      if (m[1]) mstate = (mstate == 0) ? 1 : 0;
      else if (m[3] && LAP_EN) begin
        if (mstate == 1) begin
          mstate = 2;
          mheld  = pre;
        end else if (mstate == 2) begin
          mstate = 1;
        end
      end
    end
    e.due  = cyc + 4;
    e.disp = to_bcd((mstate == 2) ? mheld : mcs);
    e.run  = (mstate != 0);
    e.lapa = (mstate == 2);
    sb.push_back(e);
    {lap, clr, ss, tick_in} = m;
    step(1);
    {lap, clr, ss, tick_in} = 4'b0000;
    step(2);
  endtask

  task automatic settle(output exp_t e);
    step(2);
    e = '0;
    while (sb.size() > 0) e = sb.pop_front();
  endtask

  task automatic run_ticks(input int unsigned n, input string tag);
    exp_t e;
    bit   got;
    for (int unsigned i = 0; i < n; i++) begin
      drive(4'b0001);
      got = 1'b0;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e   = sb.pop_front();
        got = 1'b1;
      end
      if (got) begin
        n_cmp++;
        if (obs !== e.disp || running !== e.run || lap_active !== e.lapa) begin
          n_bad++;
          $display("FAIL %s tick %0d: got disp=%h run=%b lap=%b, want disp=%h run=%b lap=%b",
                   tag, i, obs, running, lap_active, e.disp, e.run, e.lapa);
        end
      end
    end
  endtask

  task automatic test_reset();
    exp_t e;
    #1 reset_n = 1'b0;
    step(2);
    n_cmp++; if (obs !== 24'h0)    begin n_bad++; $display("FAIL reset_disp: got %h want 000000", obs); end
    n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL reset_running: got %b want 0", running); end
    n_cmp++; if (lap_active !== 1'b0) begin n_bad++; $display("FAIL reset_lap: got %b want 0", lap_active); end
    n_cmp++; if (wrap !== 1'b0)    begin n_bad++; $display("FAIL reset_wrap: got %b want 0", wrap); end
    reset_n = 1'b1;
    step(1);
    drive(4'b0001);
    drive(4'b0001);
    settle(e);
    n_cmp++;
    if (obs !== e.disp || running !== 1'b0) begin
      n_bad++; $display("FAIL stopped_ticks: got %h run=%b want %h run=0", obs, running, e.disp);
    end
  endtask

  task automatic test_start_150();
    exp_t e;
    drive(4'b0010);
    run_ticks(150, "start_150");
    settle(e);
    n_cmp++;
    if (obs !== 24'h000150 || obs !== e.disp || running !== 1'b1) begin
      n_bad++; $display("FAIL start_150: got %h run=%b want 000150 run=1", obs, running);
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    drive(4'b0100);
    drive(4'b0010);
    run_ticks(5999, "to_0059");
    settle(e);
    n_cmp++; if (obs !== 24'h005999) begin n_bad++; $display("FAIL at_0059: got %h want 005999", obs); end
    drive(4'b0001);
    settle(e);
    n_cmp++; if (obs !== 24'h010000 || obs !== e.disp) begin n_bad++; $display("FAIL minute_carry: got %h want 010000", obs); end
    n_cmp++; if (wrap_cnt !== 0) begin n_bad++; $display("FAIL minute_no_wrap: got %0d wrap pulses want 0", wrap_cnt); end
    run_ticks(5999, "to_0159");
    settle(e);
    n_cmp++; if (obs !== 24'h015999) begin n_bad++; $display("FAIL at_max: got %h want 015999", obs); end
    drive(4'b0001);
    step(1);
    while (sb.size() > 0) e = sb.pop_front();
    n_cmp++;
    if (obs !== 24'h0 || obs !== e.disp || wrap !== 1'b1 || running !== 1'b1) begin
      n_bad++; $display("FAIL wrap_edge: got %h wrap=%b run=%b want 000000 wrap=1 run=1", obs, wrap, running);
    end
    step(1);
    n_cmp++; if (wrap !== 1'b0) begin n_bad++; $display("FAIL wrap_width: got wrap=%b want 0", wrap); end
    n_cmp++; if (wrap_cnt !== 1) begin n_bad++; $display("FAIL wrap_count: got %0d want 1", wrap_cnt); end
  endtask

  task automatic test_clear_with_tick();
    exp_t e;
    run_ticks(1234, "to_1234");
    settle(e);
    n_cmp++; if (obs !== 24'h001234) begin n_bad++; $display("FAIL at_1234: got %h want 001234", obs); end
    drive(4'b0101);
    settle(e);
    n_cmp++;
    if (obs !== 24'h0 || obs !== e.disp || running !== 1'b0) begin
      n_bad++; $display("FAIL clear_tick: got %h run=%b want 000000 run=0", obs, running);
    end
    drive(4'b0001);
    settle(e);
    n_cmp++; if (obs !== e.disp) begin n_bad++; $display("FAIL cleared_idle: got %h want %h", obs, e.disp); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    drive(4'b0010);
    run_ticks(10, "pre_stop");
    drive(4'b0011);
    settle(e);
    n_cmp++;
    if (obs !== 24'h000011 || obs !== e.disp || running !== 1'b0) begin
      n_bad++; $display("FAIL stop_tick: got %h run=%b want 000011 run=0", obs, running);
    end
    drive(4'b1010);
    settle(e);
    n_cmp++;
    if (running !== 1'b1 || lap_active !== 1'b0 || obs !== e.disp) begin
      n_bad++; $display("FAIL ss_lap: got run=%b lap=%b disp=%h want run=1 lap=0 disp=%h",
                        running, lap_active, obs, e.disp);
    end
  endtask

  task automatic test_lap();
    exp_t e;
    drive(4'b0100);
    drive(4'b0010);
    run_ticks(500, "to_0500");
    drive(4'b1000);
    run_ticks(300, "lap_hold");
    settle(e);
    n_cmp++;
    if (obs !== e.disp || lap_active !== e.lapa || running !== 1'b1) begin
      n_bad++; $display("FAIL lap_hold: got %h lap=%b want %h lap=%b", obs, lap_active, e.disp, e.lapa);
    end
    drive(4'b1000);
    settle(e);
    n_cmp++;
    if (obs !== 24'h000800 || lap_active !== 1'b0) begin
      n_bad++; $display("FAIL lap_release: got %h lap=%b want 000800 lap=0", obs, lap_active);
    end
    drive(4'b1000);
    run_ticks(20, "lap_again");
    drive(4'b0010);
    settle(e);
    n_cmp++;
    if (obs !== e.disp || running !== 1'b0 || lap_active !== 1'b0) begin
      n_bad++; $display("FAIL lap_stop: got %h run=%b lap=%b want %h run=0 lap=0",
                        obs, running, lap_active, e.disp);
    end
  endtask

  task automatic test_reset_midcount();
    exp_t e;
    drive(4'b0100);
    drive(4'b0010);
    run_ticks(4217, "to_4217");
    settle(e);
    n_cmp++; if (obs !== 24'h004217) begin n_bad++; $display("FAIL at_4217: got %h want 004217", obs); end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if (obs !== 24'h0 || running !== 1'b0 || lap_active !== 1'b0 || wrap !== 1'b0) begin
      n_bad++; $display("FAIL async_reset: got %h run=%b lap=%b wrap=%b want all 0",
                        obs, running, lap_active, wrap);
    end
    mstate = 0;
    mcs    = 0;
    sb.delete();
    step(1);
    reset_n = 1'b1;
    step(1);
    drive(4'b0001);
    drive(4'b0001);
    drive(4'b0001);
    settle(e);
    n_cmp++;
    if (obs !== 24'h0 || obs !== e.disp || running !== 1'b0) begin
      n_bad++; $display("FAIL post_reset: got %h run=%b want 000000 run=0", obs, running);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_start_150();
    test_wrap();
    test_clear_with_tick();
    test_back_to_back();
    test_lap();
    test_reset_midcount();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
